// File: rtl/serial_pe_ctrl_if.sv
// Purpose: job handshake, buffer read/write and PE-side signals of serial_pe_ctrl in one bundle.
// Latency: none; this bundle holds wires only.
// Backpressure: none; every consumer must take one element per cycle.
interface serial_pe_ctrl_if #(
    parameter int ADDR_W = 12,
    parameter int LEN_W  = 10
);
    // job handshake
    logic              start;
    logic [LEN_W-1:0]  vec_len;
    logic [LEN_W-1:0]  out_num;
    logic              busy;
    logic              done;

    // neuron / weight buffer read port
    logic              rd_en;
    logic [ADDR_W-1:0] neuron_addr;
    logic [ADDR_W-1:0] weight_addr;
    logic [15:0]       neuron_rdata;
    logic [15:0]       weight_rdata;

    // processing element
    logic [15:0]       pe_neuron;
    logic [15:0]       pe_weight;
    logic [1:0]        pe_ctl;
    logic              pe_vld;
    logic [31:0]       pe_result;
    logic              pe_vld_o;

    // output buffer write port
    logic              out_wr_en;
    logic [ADDR_W-1:0] out_addr;
    logic [31:0]       out_wdata;

    // controller side
    modport master (
        input  start, vec_len, out_num,
        output busy, done,
        output rd_en, neuron_addr, weight_addr,
        input  neuron_rdata, weight_rdata,
        output pe_neuron, pe_weight, pe_ctl, pe_vld,
        input  pe_result, pe_vld_o,
        output out_wr_en, out_addr, out_wdata
    );

    // environment side: requester, buffers and PE
    modport slave (
        output start, vec_len, out_num,
        input  busy, done,
        input  rd_en, neuron_addr, weight_addr,
        output neuron_rdata, weight_rdata,
        input  pe_neuron, pe_weight, pe_ctl, pe_vld,
        output pe_result, pe_vld_o,
        input  out_wr_en, out_addr, out_wdata
    );
endinterface

// File: rtl/serial_pe_ctrl.sv
// Purpose: sequences serial_pe through a matrix-vector job (out_num dot products of vec_len MACs).
// Latency: start to done is vec_len*out_num+3 cycles; a zero-length job finishes in 1 cycle.
// Backpressure: none; buffers and PE must accept one element per cycle, and start is ignored unless idle.
module serial_pe_ctrl #(
    parameter int ADDR_W = 12,
    parameter int LEN_W  = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    serial_pe_ctrl_if.master  bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [LEN_W-1:0]  LEN_ONE  = LEN_W'(1);
    localparam logic [LEN_W-1:0]  LEN_ZERO = '0;
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    logic [1:0]        state_q,   state_d;
    logic [LEN_W-1:0]  vec_len_q, vec_len_d;
    logic [LEN_W-1:0]  out_num_q, out_num_d;
    logic [LEN_W-1:0]  k_q,       k_d;        // element index within the current dot product
    logic [LEN_W-1:0]  j_q,       j_d;        // dot product currently being read
    logic [LEN_W-1:0]  wr_cnt_q,  wr_cnt_d;   // results already written
    logic [ADDR_W-1:0] w_q,       w_d;        // running weight address across the whole job
    logic              pe_vld_q;
    logic [1:0]        pe_ctl_q;

    logic rd_en;
    logic busy;
    logic wr_fire;
    logic k_last;
    logic j_last;
    logic wr_last;

    // Decode state and counter boundaries; out_wr_en only counts while a job is live.
    always_comb begin
        rd_en   = (state_q == ST_RUN);
        busy    = (state_q == ST_RUN) || (state_q == ST_DRAIN);
        wr_fire = bus.pe_vld_o && busy;
        k_last  = (k_q == (vec_len_q - LEN_ONE));
        j_last  = (j_q == (out_num_q - LEN_ONE));
        wr_last = (wr_cnt_q == (out_num_q - LEN_ONE));
    end

    // Next-state logic for the job FSM and all address/length counters.
    always_comb begin
        state_d   = state_q;
        vec_len_d = vec_len_q;
        out_num_d = out_num_q;
        k_d       = k_q;
        j_d       = j_q;
        w_d       = w_q;
        wr_cnt_d  = wr_cnt_q;

        // Writes land during RUN as well as DRAIN, so the write counter runs independently.
        if (wr_fire) begin
            wr_cnt_d = wr_cnt_q + LEN_ONE;
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    if ((bus.vec_len == LEN_ZERO) || (bus.out_num == LEN_ZERO)) begin
                        // Nothing to compute: report completion without touching the buffers.
                        state_d = ST_DONE;
                    end else begin
                        vec_len_d = bus.vec_len;
                        out_num_d = bus.out_num;
                        k_d       = '0;
                        j_d       = '0;
                        w_d       = '0;
                        wr_cnt_d  = '0;
                        state_d   = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                // One read per cycle; no bubble between consecutive dot products.
                w_d = w_q + ADDR_ONE;
                if (k_last) begin
                    k_d = '0;
                    j_d = j_q + LEN_ONE;
                    if (j_last) begin
                        state_d = ST_DRAIN;
                    end
                end else begin
                    k_d = k_q + LEN_ONE;
                end
            end
            ST_DRAIN: begin
                // Wait for the final PE result to be written out.
                if (wr_fire && wr_last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            vec_len_q <= '0;
            out_num_q <= '0;
            k_q       <= '0;
            j_q       <= '0;
            w_q       <= '0;
            wr_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            vec_len_q <= vec_len_d;
            out_num_q <= out_num_d;
            k_q       <= k_d;
            j_q       <= j_d;
            w_q       <= w_d;
            wr_cnt_q  <= wr_cnt_d;
        end
    end

    // Align PE valid/control with buffer data, which arrives one cycle after the read strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pe_vld_q <= 1'b0;
            pe_ctl_q <= 2'b00;
        end else begin
            pe_vld_q    <= rd_en;
            pe_ctl_q[0] <= rd_en && (k_q == LEN_ZERO);
            pe_ctl_q[1] <= rd_en && k_last;
        end
    end

    // Drive the bundle; data paths are straight pass-throughs.
    always_comb begin
        bus.busy        = busy;
        bus.done        = (state_q == ST_DONE);
        bus.rd_en       = rd_en;
        bus.neuron_addr = ADDR_W'(k_q);
        bus.weight_addr = w_q;
        bus.pe_neuron   = bus.neuron_rdata;
        bus.pe_weight   = bus.weight_rdata;
        bus.pe_ctl      = pe_ctl_q;
        bus.pe_vld      = pe_vld_q;
        bus.out_wr_en   = wr_fire;
        bus.out_addr    = ADDR_W'(wr_cnt_q);
        bus.out_wdata   = bus.pe_result;
    end

endmodule

// File: tb/tb_serial_pe_ctrl.sv
// Bench for serial_pe_ctrl: buffer and serial_pe models around the controller, directed jobs.
// Cycle c is the clock period that ends at edge c, counting from the edge that accepts start as edge 0.
// Outputs are sampled on the falling edge; inputs change 1 ns after a rising edge.
module tb_serial_pe_ctrl;

    localparam int AW = 12;
    localparam int LW = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    serial_pe_ctrl_if #(.ADDR_W(AW), .LEN_W(LW)) bus ();

    serial_pe_ctrl #(.ADDR_W(AW), .LEN_W(LW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // synchronous-read neuron and weight buffers
    logic [15:0] nmem [0:63];
    logic [15:0] wmem [0:63];

    always @(posedge clk) begin
        if (bus.rd_en) begin
            bus.neuron_rdata <= nmem[bus.neuron_addr[5:0]];
            bus.weight_rdata <= wmem[bus.weight_addr[5:0]];
        end
    end

    // serial_pe model: signed 16x16 MAC, ctl[0] loads, ctl[1] emits one cycle later
    logic signed [31:0] acc;
    logic signed [31:0] prod;
    logic signed [31:0] sum;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc           <= '0;
            bus.pe_result <= '0;
            bus.pe_vld_o  <= 1'b0;
        end else begin
            bus.pe_vld_o <= 1'b0;
            if (bus.pe_vld) begin
                prod = $signed(bus.pe_neuron) * $signed(bus.pe_weight);
                sum  = bus.pe_ctl[0] ? prod : (acc + prod);
                acc <= sum;
                if (bus.pe_ctl[1]) begin
                    bus.pe_result <= sum;
                    bus.pe_vld_o  <= 1'b1;
                end
            end
        end
    end

    // observation log, restarted whenever a new job id appears
    bit          trk = 1'b0;
    int          job_id = 0;
    int          seen_id = 0;
    int          mcyc = 0;
    int          nwr = 0, ndone = 0, done_c = 0;
    int          nrd = 0, rd_first = 0, rd_last = 0;
    int          nvld = 0, vld_first = 0, vld_last = 0;
    int          nbusy = 0, busy_first = 0, busy_last = 0;
    logic [31:0] wr_a [0:7];
    logic [31:0] wr_d [0:7];
    logic [31:0] wr_c [0:7];
    logic [31:0] ctl_pack = '0;

    always @(negedge clk) begin
        if (trk) begin
            if (job_id != seen_id) begin
                seen_id  = job_id;
                mcyc     = 0;
                nwr      = 0; ndone = 0; done_c = 0;
                nrd      = 0; rd_first = 0; rd_last = 0;
                nvld     = 0; vld_first = 0; vld_last = 0;
                nbusy    = 0; busy_first = 0; busy_last = 0;
                ctl_pack = '0;
            end
            mcyc = mcyc + 1;
            if (bus.out_wr_en) begin
                if (nwr < 8) begin
                    wr_a[nwr] = 32'(bus.out_addr);
                    wr_d[nwr] = bus.out_wdata;
                    wr_c[nwr] = mcyc;
                end
                nwr = nwr + 1;
            end
            if (bus.done) begin
                if (ndone == 0) done_c = mcyc;
                ndone = ndone + 1;
            end
            if (bus.rd_en) begin
                if (nrd == 0) rd_first = mcyc;
                rd_last = mcyc;
                nrd = nrd + 1;
            end
            if (bus.pe_vld) begin
                if (nvld == 0) vld_first = mcyc;
                vld_last = mcyc;
                nvld = nvld + 1;
                ctl_pack = {ctl_pack[29:0], bus.pe_ctl};
            end
            if (bus.busy) begin
                if (nbusy == 0) busy_first = mcyc;
                busy_last = mcyc;
                nbusy = nbusy + 1;
            end
        end
    end

    int n_vec = 0;
    int n_miss = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (obs !== exp) begin
            n_miss = n_miss + 1;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // called 1 ns after a rising edge; returns 1 ns into cycle 1
    task automatic begin_job(input int vl, input int on);
        trk         = 1'b0;
        bus.start   = 1'b1;
        bus.vec_len = vl[LW-1:0];
        bus.out_num = on[LW-1:0];
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        job_id    = job_id + 1;
        trk       = 1'b1;
    endtask

    task automatic check_wr(input string tag, input int i, input logic [31:0] a,
                            input logic [31:0] d, input int c);
        check_val({tag, "_addr"}, wr_a[i], a);
        check_val({tag, "_data"}, wr_d[i], d);
        check_val({tag, "_cyc"},  wr_c[i], c);
    endtask

    initial begin
        bus.start   = 1'b0;
        bus.vec_len = '0;
        bus.out_num = '0;
        for (int i = 0; i < 64; i++) begin
            nmem[i] = '0;
            wmem[i] = '0;
        end

        // reset values
        #2;
        check_val("rst_busy",   32'(bus.busy),        0);
        check_val("rst_done",   32'(bus.done),        0);
        check_val("rst_rd_en",  32'(bus.rd_en),       0);
        check_val("rst_pe_vld", 32'(bus.pe_vld),      0);
        check_val("rst_pe_ctl", 32'(bus.pe_ctl),      0);
        check_val("rst_naddr",  32'(bus.neuron_addr), 0);
        check_val("rst_waddr",  32'(bus.weight_addr), 0);
        check_val("rst_oaddr",  32'(bus.out_addr),    0);
        check_val("rst_wr_en",  32'(bus.out_wr_en),   0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(2);

        // basic 3x2 job
        nmem[0] = 16'd1; nmem[1] = 16'd2; nmem[2] = 16'd3;
        wmem[0] = 16'd1; wmem[1] = 16'd1; wmem[2] = 16'd1;
        wmem[3] = 16'd2; wmem[4] = 16'd2; wmem[5] = 16'd2;
        begin_job(3, 2);
        step(11);
        check_val("b_nwr", nwr, 2);
        check_wr("b_w0", 0, 0, 32'd6, 5);
        check_wr("b_w1", 1, 1, 32'd12, 8);
        check_val("b_done_cyc", done_c, 9);
        check_val("b_ndone", ndone, 1);
        check_val("b_ctl_seq", ctl_pack, 32'h492);
        check_val("b_rd_n", nrd, 6);
        check_val("b_rd_first", rd_first, 1);
        check_val("b_rd_last", rd_last, 6);
        check_val("b_vld_first", vld_first, 2);
        check_val("b_vld_last", vld_last, 7);
        check_val("b_busy_n", nbusy, 8);
        check_val("b_busy_first", busy_first, 1);
        check_val("b_busy_last", busy_last, 8);

        // vec_len = 1, out_num = 4
        nmem[0] = 16'd5;
        wmem[0] = 16'd1; wmem[1] = 16'hFFFF; wmem[2] = 16'd2; wmem[3] = 16'hFFFE;
        begin_job(1, 4);
        step(9);
        check_val("v1_ctl_seq", ctl_pack, 32'h0000_00FF);
        check_val("v1_nvld", nvld, 4);
        check_val("v1_nwr", nwr, 4);
        check_wr("v1_w0", 0, 0, 32'd5, 3);
        check_wr("v1_w1", 1, 1, 32'hFFFF_FFFB, 4);
        check_wr("v1_w2", 2, 2, 32'd10, 5);
        check_wr("v1_w3", 3, 3, 32'hFFFF_FFF6, 6);
        check_val("v1_done_cyc", done_c, 7);

        // zero-length job
        begin_job(0, 7);
        step(5);
        check_val("z_done_cyc", done_c, 1);
        check_val("z_ndone", ndone, 1);
        check_val("z_nrd", nrd, 0);
        check_val("z_nvld", nvld, 0);
        check_val("z_nwr", nwr, 0);
        check_val("z_nbusy", nbusy, 0);

        // signed extremes wrap to 0x80000000
        nmem[0] = 16'h8000; nmem[1] = 16'h8000;
        wmem[0] = 16'h8000; wmem[1] = 16'h8000;
        begin_job(2, 1);
        step(7);
        check_val("s_nwr", nwr, 1);
        check_wr("s_w0", 0, 0, 32'h8000_0000, 4);
        check_val("s_done_cyc", done_c, 5);

        // start while busy is ignored; lengths are latched
        nmem[0] = 16'd1; nmem[1] = 16'd2; nmem[2] = 16'd3;
        wmem[0] = 16'd1; wmem[1] = 16'd1; wmem[2] = 16'd1;
        wmem[3] = 16'd2; wmem[4] = 16'd2; wmem[5] = 16'd2;
        begin_job(3, 2);
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
        step(2);
        bus.start   = 1'b1;
        bus.vec_len = 10'd7;
        step(1);
        bus.start = 1'b0;
        step(5);
        check_val("sb_ndone", ndone, 1);
        check_val("sb_done_cyc", done_c, 9);
        check_val("sb_nwr", nwr, 2);
        check_val("sb_w0_data", wr_d[0], 32'd6);
        check_val("sb_w1_data", wr_d[1], 32'd12);
        // start in the cycle right after done
        begin_job(1, 1);
        step(6);
        check_val("sb2_done_cyc", done_c, 4);
        check_val("sb2_nwr", nwr, 1);
        check_wr("sb2_w0", 0, 0, 32'd1, 3);

        // reset in cycle 3 of a 4x4 job
        begin_job(4, 4);
        step(2);
        check_val("r_pre_rd_en", 32'(bus.rd_en), 1);
        rst_n = 1'b0;
        #1;
        check_val("r_rd_en", 32'(bus.rd_en), 0);
        check_val("r_pe_vld", 32'(bus.pe_vld), 0);
        check_val("r_busy", 32'(bus.busy), 0);
        check_val("r_done", 32'(bus.done), 0);
        step(3);
        rst_n = 1'b1;
        step(6);
        check_val("r_ndone", ndone, 0);
        check_val("r_nwr", nwr, 0);
        // restarted 2x2 job
        nmem[0] = 16'd3; nmem[1] = 16'hFFFC;
        wmem[0] = 16'd2; wmem[1] = 16'd5; wmem[2] = 16'hFFFF; wmem[3] = 16'd7;
        begin_job(2, 2);
        step(9);
        check_val("r2_nwr", nwr, 2);
        check_wr("r2_w0", 0, 0, 32'hFFFF_FFF2, 4);
        check_wr("r2_w1", 1, 1, 32'hFFFF_FFE1, 6);
        check_val("r2_done_cyc", done_c, 7);
        check_val("r2_ndone", ndone, 1);

        trk = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
